// File: rtl/pipeline_fetch_unit.sv
// Instruction-fetch front end. It owns the PC, issues requests to instruction
// memory, tracks responses that are still in flight, and buffers up to two
// returned instructions for the decode-stage latch.
//
// Handshakes: a transfer happens on a channel only in a cycle where valid and
// ready are both high. Once imem_req_valid is raised, it and imem_req_addr hold
// until the request is accepted. The one exception is a redirect, which
// withdraws the request.
//
// Occupancy: live (L), drop (D) and buffered (B) together never exceed two.
// This is the credit that stops the buffer from overflowing.
module pipeline_fetch_unit #(
  parameter int                 ADDR_W   = 24,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  // Architectural and bookkeeping state.
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ifl0_q, ifl0_d;     // in-flight PC FIFO, entry 0 = head
  logic [ADDR_W-1:0] ifl1_q, ifl1_d;
  logic [1:0]        live_q, live_d;     // requests whose response we still want
  logic [1:0]        drop_q, drop_d;     // stale responses still to be discarded
  logic [31:0]       buf0_instr_q, buf0_instr_d;  // output buffer, entry 0 = head
  logic [ADDR_W-1:0] buf0_pc_q, buf0_pc_d;
  logic [31:0]       buf1_instr_q, buf1_instr_d;
  logic [ADDR_W-1:0] buf1_pc_q, buf1_pc_d;
  logic [1:0]        bcnt_q, bcnt_d;

  // Handshake and event decode.
  logic [2:0] occ;
  logic       req_valid;
  logic       accept;
  logic       consume;
  logic       rsp_drop;
  logic       rsp_take;
  logic [1:0] live_after_pop;
  logic [1:0] bcnt_after_pop;

  // Decode the credit, the handshakes and what this cycle's response does.
  always_comb begin
    occ       = {1'b0, live_q} + {1'b0, drop_q} + {1'b0, bcnt_q};
    req_valid = !rst && !redirect_en && (occ < 3'd2);
    accept    = req_valid && imem_req_ready;
    consume   = (bcnt_q != 2'd0) && fetch_en && !redirect_en;
    rsp_drop  = imem_rsp_valid && (drop_q != 2'd0);
    rsp_take  = imem_rsp_valid && (drop_q == 2'd0) && (live_q != 2'd0);
    live_after_pop = live_q - {1'b0, rsp_take};
    bcnt_after_pop = bcnt_q - {1'b0, consume};
  end

  // Next-state logic. A redirect takes priority over every other event.
  always_comb begin
    pc_d         = pc_q;
    ifl0_d       = ifl0_q;
    ifl1_d       = ifl1_q;
    live_d       = live_q;
    drop_d       = drop_q;
    buf0_instr_d = buf0_instr_q;
    buf0_pc_d    = buf0_pc_q;
    buf1_instr_d = buf1_instr_q;
    buf1_pc_d    = buf1_pc_q;
    bcnt_d       = bcnt_q;

    if (redirect_en) begin
      // Every request still outstanding becomes one to discard. A response
      // arriving in this same cycle retires one of them immediately.
      drop_d = live_q + drop_q - {1'b0, (imem_rsp_valid && ((live_q != 2'd0) || (drop_q != 2'd0)))};
      live_d = 2'd0;
      bcnt_d = 2'd0;
      pc_d   = redirect_pc & ~ADDR_W'(3);
    end else begin
      // In-flight FIFO: pop the head on a kept response, then append an accepted request.
      if (rsp_take) begin
        ifl0_d = ifl1_q;
      end
      if (accept) begin
        if (live_after_pop == 2'd0) begin
          ifl0_d = pc_q;
        end else begin
          ifl1_d = pc_q;
        end
        pc_d = pc_q + ADDR_W'(4);
      end
      live_d = live_after_pop + {1'b0, accept};
      drop_d = drop_q - {1'b0, rsp_drop};

      // Output buffer: pop the head on a consume, then append a kept response.
      if (consume) begin
        buf0_instr_d = buf1_instr_q;
        buf0_pc_d    = buf1_pc_q;
      end
      if (rsp_take) begin
        if (bcnt_after_pop == 2'd0) begin
          buf0_instr_d = imem_rsp_data;
          buf0_pc_d    = ifl0_q;
        end else begin
          buf1_instr_d = imem_rsp_data;
          buf1_pc_d    = ifl0_q;
        end
      end
      bcnt_d = bcnt_after_pop + {1'b0, rsp_take};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifl0_q       <= '0;
      ifl1_q       <= '0;
      live_q       <= 2'd0;
      drop_q       <= 2'd0;
      buf0_instr_q <= 32'd0;
      buf0_pc_q    <= '0;
      buf1_instr_q <= 32'd0;
      buf1_pc_q    <= '0;
      bcnt_q       <= 2'd0;
    end else begin
      pc_q         <= pc_d;
      ifl0_q       <= ifl0_d;
      ifl1_q       <= ifl1_d;
      live_q       <= live_d;
      drop_q       <= drop_d;
      buf0_instr_q <= buf0_instr_d;
      buf0_pc_q    <= buf0_pc_d;
      buf1_instr_q <= buf1_instr_d;
      buf1_pc_q    <= buf1_pc_d;
      bcnt_q       <= bcnt_d;
    end
  end

  // Output drive.
  always_comb begin
    imem_req_valid = req_valid;
    imem_req_addr  = pc_q;
    if_valid       = (bcnt_q != 2'd0);
    if_instr       = buf0_instr_q;
    if_pc          = buf0_pc_q;
  end

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: in-order instruction memory model with
// configurable latency, a queue-based model of the fetch rules, and a stream
// check that decoded PCs run consecutively from each restart point.
module tb_pipeline_fetch_unit;

  localparam logic [23:0] RPC = 24'h000000;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_en;
  logic [23:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [23:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [23:0] if_pc;

  pipeline_fetch_unit #(.ADDR_W(24), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  // Clock.
  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_passed = 0;
  int cyc = 0;
  int lat = 1;

  // Reference model state.
  logic [23:0] m_pc;
  logic [23:0] m_infl[$];
  int          m_drop;
  logic [55:0] exp_q[$];          // {instr, pc} waiting for decode
  logic [23:0] exp_next;          // next PC the decode stream must see
  logic        exp_rv;

  // Memory model state.
  logic [23:0] mem_a[$];
  int          mem_due[$];
  logic        rsp_sent;
  logic        cur_acc;
  logic [23:0] cur_addr;
  logic [23:0] acc_log[$];
  logic        prev_hold;
  logic [23:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {a[7:0] ^ 8'h5A, a} ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle's inputs at the falling edge and compare against the model.
  task automatic cyc_begin(input logic r, input logic fe, input logic re,
                           input logic [23:0] rpc, input logic rdy);
    @(negedge clk);
    rst = r; fetch_en = fe; redirect_en = re; redirect_pc = rpc; imem_req_ready = rdy;
    if (!r && mem_a.size() > 0 && mem_due[0] <= cyc) begin
      rsp_sent = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mem_a[0]);
    end else begin
      rsp_sent = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    #1;
    exp_rv = !r && !re && (m_infl.size() + m_drop + exp_q.size() < 2);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("req_addr", 32'(imem_req_addr), 32'(m_pc));
    chk("if_valid", 32'(if_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("if_pc", 32'(if_pc), 32'(exp_q[0][23:0]));
      chk("if_instr", if_instr, exp_q[0][55:24]);
    end
    if (prev_hold && !re && !r) chk("addr_stable", 32'(imem_req_addr), 32'(prev_addr));
    if (if_valid && fe && !re && !r) begin
      chk("stream_pc", 32'(if_pc), 32'(exp_next));
      chk("stream_instr", if_instr, mem_word(if_pc));
      exp_next = exp_next + 24'd4;
    end
    cur_acc   = imem_req_valid && rdy;
    cur_addr  = imem_req_addr;
    prev_hold = imem_req_valid && !rdy;
    prev_addr = imem_req_addr;
  endtask

  // Advance through the rising edge: update the model and the memory.
  task automatic cyc_end();
    logic        r, fe, re, rv, rdy;
    logic [23:0] rpc;
    logic [23:0] p;
    int          pend;
    r = rst; fe = fetch_en; re = redirect_en; rv = imem_rsp_valid; rdy = imem_req_ready;
    rpc = redirect_pc;
    @(posedge clk);
    if (r) begin
      m_pc = RPC; m_infl.delete(); m_drop = 0; exp_q.delete(); exp_next = RPC;
      prev_hold = 1'b0;
    end else if (re) begin
      pend = m_infl.size() + m_drop;
      m_drop = pend - ((rv && pend > 0) ? 1 : 0);
      m_infl.delete(); exp_q.delete();
      m_pc = rpc & ~24'h3;
      exp_next = m_pc;
    end else begin
      if (exp_q.size() > 0 && fe) void'(exp_q.pop_front());
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else if (m_infl.size() > 0) begin
          p = m_infl.pop_front();
          exp_q.push_back({mem_word(p), p});
        end
      end
      if (exp_rv && rdy) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + 24'd4;
      end
    end
    if (rsp_sent) begin
      void'(mem_a.pop_front());
      void'(mem_due.pop_front());
    end
    if (r) begin
      mem_a.delete(); mem_due.delete();
    end else if (cur_acc) begin
      mem_a.push_back(cur_addr); mem_due.push_back(cyc + lat);
      acc_log.push_back(cur_addr);
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic fe, input logic rdy);
    for (int i = 0; i < n; i++) begin
      cyc_begin(1'b0, fe, 1'b0, 24'h0, rdy);
      cyc_end();
    end
  endtask

  initial begin
    logic found;
    int   idx;
    rst = 1'b1; fetch_en = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    m_pc = RPC; m_drop = 0; exp_next = RPC; prev_hold = 1'b0; rsp_sent = 1'b0;
    repeat (2) @(posedge clk);

    // Checked reset cycle.
    cyc_begin(1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    cyc_end();

    // Latency 1, ready high: first request right after reset, first if_valid two cycles later.
    lat = 1;
    cyc_begin(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", 32'(imem_req_addr), 32'h0);
    chk("reset_if_valid", 32'(if_valid), 32'd0);
    chk("reset_if_instr", if_instr, 32'd0);
    chk("reset_if_pc", 32'(if_pc), 32'd0);
    cyc_end();
    run(1, 1'b1, 1'b1);
    cyc_begin(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
    chk("first_if_valid", 32'(if_valid), 32'd1);
    chk("first_if_pc", 32'(if_pc), 32'h0);
    cyc_end();
    run(17, 1'b1, 1'b1);

    // Stall for five cycles: buffer fills, issue stops, output frozen.
    run(4, 1'b0, 1'b1);
    cyc_begin(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
    chk("stall_if_valid", 32'(if_valid), 32'd1);
    chk("stall_no_issue", 32'(imem_req_valid), 32'd0);
    cyc_end();
    run(10, 1'b1, 1'b1);

    // Redirect timing with latency 1: request N+1, if_valid N+3.
    cyc_begin(1'b0, 1'b1, 1'b1, 24'h000203, 1'b1);
    cyc_end();
    cyc_begin(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
    chk("redir_req_addr", 32'(imem_req_addr), 32'h000200);
    chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
    cyc_end();
    run(1, 1'b1, 1'b1);
    cyc_begin(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
    chk("redir_if_valid", 32'(if_valid), 32'd1);
    chk("redir_if_pc", 32'(if_pc), 32'h000200);
    cyc_end();
    run(6, 1'b1, 1'b1);

    // Latency 3: redirect to 0x000103 while two requests are in flight.
    lat = 3;
    for (int i = 0; i < 12 && m_infl.size() != 2; i++) run(1, 1'b1, 1'b1);
    chk("two_in_flight", 32'(m_infl.size()), 32'd2);
    cyc_begin(1'b0, 1'b1, 1'b1, 24'h000103, 1'b1);
    cyc_end();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc_begin(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
      if (if_valid) begin
        chk("redir103_first_pc", 32'(if_pc), 32'h000100);
        found = 1'b1;
      end
      cyc_end();
    end
    if (!found) chk("redir103_timeout", 32'd0, 32'd1);

    // Random ready, stalls and redirects with latency 3.
    for (int i = 0; i < 400; i++) begin
      cyc_begin(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
                24'($urandom), 1'($urandom_range(0, 1)));
      cyc_end();
    end
    run(10, 1'b1, 1'b1);

    // PC wrap at the top of the 24-bit space.
    lat = 1;
    cyc_begin(1'b0, 1'b1, 1'b1, 24'hFFFFF8, 1'b1);
    cyc_end();
    acc_log.delete();
    run(12, 1'b1, 1'b1);
    idx = -1;
    for (int i = 0; i + 1 < acc_log.size(); i++) if (idx < 0 && acc_log[i] == 24'hFFFFFC) idx = i;
    if (idx < 0) chk("wrap_seen", 32'd0, 32'd1);
    else chk("wrap_addr", 32'(acc_log[idx + 1]), 32'h000000);

    // Reset mid-stream with the buffer full.
    run(6, 1'b0, 1'b1);
    chk("full_before_rst", 32'(exp_q.size()), 32'd2);
    cyc_begin(1'b1, 1'b0, 1'b0, 24'h0, 1'b1);
    cyc_end();
    cyc_begin(1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
    chk("post_rst_if_valid", 32'(if_valid), 32'd0);
    chk("post_rst_if_instr", if_instr, 32'd0);
    chk("post_rst_if_pc", 32'(if_pc), 32'd0);
    chk("post_rst_addr", 32'(imem_req_addr), 32'(RPC));
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    cyc_end();
    run(10, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
